ex_mem_stage_reg: RTL and testbench
===================================

# ex_mem_stage_reg

Parametrised EX/MEM pipeline stage register with valid/ready flow control, flush and bubble insertion, replacing the free-running EX/MEM latch. Sits between the execute stage (ALU, branch-target adder) and the memory stage (data memory, branch resolution). Carries full-width data, stalls cleanly under MEM back-pressure, squashes on branch flush and counts idle cycles for performance debug. An optional skid entry breaks the combinational ready path.

## Interface
- NB_PC, 32, branch-address width
- NB_DATA, 32, ALU-result and store-data width
- NB_REG, 5, destination register index width
- NB_CNT, 16, bubble-counter width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  squash every held and incoming entry this cycle
- i_ex_valid  in  1  EX presents a valid instruction
- o_ex_ready  out  1  stage accepts EX payload this cycle
- i_ex_reg_write, i_ex_mem_to_reg, i_ex_mem_read, i_ex_mem_write, i_ex_branch, i_ex_zero  in  1 each  control/flag bits
- i_ex_branch_address  in  NB_PC  branch target
- i_ex_alu_result  in  NB_DATA  ALU result / memory address
- i_ex_store_data  in  NB_DATA  register-B value for stores
- i_ex_selected_reg  in  NB_REG  destination register
- o_mem_valid  out  1  MEM payload valid
- i_mem_ready  in  1  MEM consumes payload this cycle
- o_mem_* (same ten fields as i_ex_*)  out  matching widths  registered payload
- o_bubble_count  out  NB_CNT  saturating count of cycles with o_mem_valid=0

## Operation
- Transfer in: i_ex_valid && o_ex_ready. Transfer out: o_mem_valid && i_mem_ready.
- States: EMPTY (no entry), FULL (main entry valid); SKID (main + skid valid) only with EX_MEM_SKID_EN.
- EMPTY: transfer in -> FULL, payload loaded.
- FULL: out without in -> EMPTY; out and in -> FULL with new payload; in without out (skid build only) -> SKID, payload into skid; neither -> hold, payload stable.
- SKID: out -> FULL, skid entry moves to main; no out -> hold; o_ex_ready=0.
- Flush: highest priority. Next state EMPTY; incoming payload discarded. Side-effect bits (reg_write, mem_read, mem_write, branch) of held entries forced to 0; data fields may keep stale values.
- Reset: state EMPTY; every o_mem_* output, o_mem_valid and o_bubble_count = 0.
- Control bits on o_mem_* are gated: while o_mem_valid=0, reg_write/mem_read/mem_write/branch read 0 regardless of held data.
- Bubble counter: +1 each cycle o_mem_valid=0 after the clock edge; saturates at 2^NB_CNT-1; cleared only by reset.
- Payload width per entry = 6 + NB_PC + 2*NB_DATA + NB_REG bits.

## Timing
- Latency: EX transfer at edge N -> o_mem_valid/o_mem_* at N+1.
- Full throughput: one instruction per cycle while i_mem_ready=1.
- No-skid build: o_ex_ready = !o_mem_valid || i_mem_ready (combinational from i_mem_ready).
- Skid build: o_ex_ready = !skid_valid, a pure register output; no combinational path from i_mem_ready.
- Payload never changes while o_mem_valid=1 and i_mem_ready=0, except on flush.
- i_flush with i_ex_valid in the same cycle: no transfer in; next cycle o_mem_valid=0.
- Reset asserted mid-stall: next edge EMPTY, held entries lost.

## Configuration
- EX_MEM_SKID_EN defined: second entry present, SKID state reachable, registered o_ex_ready, up to 2 entries buffered.
- Undefined: single entry, SKID state and skid registers removed, ready combinational as above.

## Structure
- Shared package: state encoding (ST_EMPTY, ST_FULL, ST_SKID), payload-width localparam, default widths NB_PC/NB_DATA/NB_REG.
- Sub-module ex_mem_entry: one payload register with load enable and control-bit clear. Instantiated once, or twice under EX_MEM_SKID_EN.

## Test plan
- Reset then idle 5 cycles -> all o_mem_* = 0, o_mem_valid=0, o_bubble_count=5.
- Stream 4 instructions, i_mem_ready=1, alu_result 0x10,0x20,0x30,0x40 -> appear in order at N+1..N+4, no bubbles.
- Load 0xDEADBEEF, hold i_mem_ready=0 for 3 cycles -> payload stable; in no-skid build o_ex_ready=0; in skid build o_ex_ready drops one cycle later after one extra accept.
- Entry with mem_write=1 held, i_flush=1 with i_ex_valid=1 -> next cycle o_mem_valid=0, o_mem_mem_write=0, incoming discarded.
- NB_CNT=4, 20 idle cycles -> o_bubble_count saturates at 15.
- NB_DATA=64, NB_PC=64: store_data 0x0123456789ABCDEF passes unaltered with 1-cycle latency.

Source files
------------

// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared definitions for the EX/MEM stage register: FSM state encoding,
// default field widths and payload layout helpers.
package ex_mem_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int unsigned DEF_NB_PC   = 32;
    localparam int unsigned DEF_NB_DATA = 32;
    localparam int unsigned DEF_NB_REG  = 5;
    localparam int unsigned DEF_NB_CNT  = 16;

    // Control bits occupy the top of the payload, MSB first:
    // reg_write, mem_to_reg, mem_read, mem_write, branch, zero.
    localparam int unsigned CTRL_W = 6;

    // Bits that cause architectural side effects downstream; cleared on squash.
    localparam logic [CTRL_W-1:0] SIDE_EFFECT_MASK = 6'b10_1110;

    function automatic int unsigned payload_width(input int unsigned nb_pc,
                                                  input int unsigned nb_data,
                                                  input int unsigned nb_reg);
        return CTRL_W + nb_pc + 2 * nb_data + nb_reg;
    endfunction

    localparam int unsigned DEF_PAYLOAD_W = payload_width(DEF_NB_PC, DEF_NB_DATA, DEF_NB_REG);

endpackage

// File: rtl/ex_mem_stage_reg_entry.sv
// One EX/MEM payload register with load enable and side-effect clear.
module ex_mem_entry
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int unsigned W = DEF_PAYLOAD_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear_ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_r;

    // Payload storage; load wins over clear so a refill is never squashed.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= d;
        end else if (clear_ctrl) begin
            data_r[W-1 -: CTRL_W] <= data_r[W-1 -: CTRL_W] & ~SIDE_EFFECT_MASK;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready flow control, flush and
// a saturating bubble counter. Define EX_MEM_SKID_EN for a registered-ready skid entry.
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int unsigned NB_PC   = DEF_NB_PC,
    parameter int unsigned NB_DATA = DEF_NB_DATA,
    parameter int unsigned NB_REG  = DEF_NB_REG,
    parameter int unsigned NB_CNT  = DEF_NB_CNT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_ex_valid,
    output logic               o_ex_ready,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_to_reg,
    input  logic               i_ex_mem_read,
    input  logic               i_ex_mem_write,
    input  logic               i_ex_branch,
    input  logic               i_ex_zero,
    input  logic [NB_PC-1:0]   i_ex_branch_address,
    input  logic [NB_DATA-1:0] i_ex_alu_result,
    input  logic [NB_DATA-1:0] i_ex_store_data,
    input  logic [NB_REG-1:0]  i_ex_selected_reg,
    output logic               o_mem_valid,
    input  logic               i_mem_ready,
    output logic               o_mem_reg_write,
    output logic               o_mem_mem_to_reg,
    output logic               o_mem_mem_read,
    output logic               o_mem_mem_write,
    output logic               o_mem_branch,
    output logic               o_mem_zero,
    output logic [NB_PC-1:0]   o_mem_branch_address,
    output logic [NB_DATA-1:0] o_mem_alu_result,
    output logic [NB_DATA-1:0] o_mem_store_data,
    output logic [NB_REG-1:0]  o_mem_selected_reg,
    output logic [NB_CNT-1:0]  o_bubble_count
);

    localparam int unsigned        PW      = payload_width(NB_PC, NB_DATA, NB_REG);
    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
    localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic              mem_valid_r;
    logic [NB_CNT-1:0] bubble_r;

    logic          take_in_s;
    logic          take_out_s;
    logic          next_valid_s;
    logic          load_main_s;
    logic          clear_main_s;
    logic [PW-1:0] ex_payload_s;
    logic [PW-1:0] main_d_s;
    logic [PW-1:0] main_q_s;

`ifdef EX_MEM_SKID_EN
    logic          ex_ready_r;
    logic          load_skid_s;
    logic          clear_skid_s;
    logic [PW-1:0] skid_q_s;

    assign o_ex_ready = ex_ready_r;
`else
    assign o_ex_ready = !mem_valid_r || i_mem_ready;
`endif

    assign ex_payload_s = {i_ex_reg_write, i_ex_mem_to_reg, i_ex_mem_read, i_ex_mem_write,
                           i_ex_branch, i_ex_zero, i_ex_branch_address, i_ex_alu_result,
                           i_ex_store_data, i_ex_selected_reg};

    // Handshake decode into entry load/clear strobes and next occupancy.
    always_comb begin
        take_in_s    = i_ex_valid && o_ex_ready && !i_flush;
        take_out_s   = mem_valid_r && i_mem_ready;
        load_main_s  = 1'b0;
        clear_main_s = 1'b0;
        main_d_s     = ex_payload_s;
        next_valid_s = 1'b0;
`ifdef EX_MEM_SKID_EN
        load_skid_s  = 1'b0;
        clear_skid_s = 1'b0;
`endif
        if (i_flush) begin
            clear_main_s = 1'b1;
`ifdef EX_MEM_SKID_EN
            clear_skid_s = 1'b1;
`endif
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    load_main_s  = take_in_s;
                    next_valid_s = take_in_s;
                end
                ST_FULL: begin
                    next_valid_s = take_in_s || !take_out_s;
                    if (take_out_s) begin
                        load_main_s  = take_in_s;
                        // Draining to empty: drop side effects so outputs read as a bubble.
                        clear_main_s = !take_in_s;
                    end else begin
`ifdef EX_MEM_SKID_EN
                        load_skid_s  = take_in_s;
`else
                        load_main_s  = 1'b0;
`endif
                    end
                end
`ifdef EX_MEM_SKID_EN
                ST_SKID: begin
                    next_valid_s = 1'b1;
                    if (take_out_s) begin
                        load_main_s  = 1'b1;
                        main_d_s     = skid_q_s;
                        clear_skid_s = 1'b1;
                    end else begin
                        load_main_s  = 1'b0;
                    end
                end
`endif
                default: begin
                    next_valid_s = 1'b0;
                    clear_main_s = 1'b1;
                end
            endcase
        end
    end

    // Occupancy FSM, registered valid/ready and saturating bubble counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r     <= ST_EMPTY;
            mem_valid_r <= 1'b0;
            bubble_r    <= '0;
`ifdef EX_MEM_SKID_EN
            ex_ready_r  <= 1'b1;
`endif
        end else begin
            mem_valid_r <= next_valid_s;
            if (!next_valid_s && (bubble_r != CNT_MAX)) begin
                bubble_r <= bubble_r + CNT_ONE;
            end else begin
                bubble_r <= bubble_r;
            end
            if (i_flush) begin
                state_r <= ST_EMPTY;
`ifdef EX_MEM_SKID_EN
                ex_ready_r <= 1'b1;
`endif
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        state_r <= take_in_s ? ST_FULL : ST_EMPTY;
                    end
                    ST_FULL: begin
                        if (take_out_s && !take_in_s) begin
                            state_r <= ST_EMPTY;
`ifdef EX_MEM_SKID_EN
                        end else if (!take_out_s && take_in_s) begin
                            state_r    <= ST_SKID;
                            ex_ready_r <= 1'b0;
`endif
                        end else begin
                            state_r <= ST_FULL;
                        end
                    end
`ifdef EX_MEM_SKID_EN
                    ST_SKID: begin
                        if (take_out_s) begin
                            state_r    <= ST_FULL;
                            ex_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_SKID;
                        end
                    end
`endif
                    default: begin
                        state_r <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    ex_mem_entry #(.W(PW)) u_main (
        .clock      (i_clock),
        .reset      (i_reset),
        .load       (load_main_s),
        .clear_ctrl (clear_main_s),
        .d          (main_d_s),
        .q          (main_q_s)
    );

`ifdef EX_MEM_SKID_EN
    ex_mem_entry #(.W(PW)) u_skid (
        .clock      (i_clock),
        .reset      (i_reset),
        .load       (load_skid_s),
        .clear_ctrl (clear_skid_s),
        .d          (ex_payload_s),
        .q          (skid_q_s)
    );
`endif

    assign {o_mem_reg_write, o_mem_mem_to_reg, o_mem_mem_read, o_mem_mem_write,
            o_mem_branch, o_mem_zero, o_mem_branch_address, o_mem_alu_result,
            o_mem_store_data, o_mem_selected_reg} = main_q_s;

    assign o_mem_valid    = mem_valid_r;
    assign o_bubble_count = bubble_r;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg (64-bit data/PC, 4-bit bubble counter)
// against a queue-based occupancy model; honours EX_MEM_SKID_EN.
module tb_ex_mem_stage_reg;

    localparam int NB_PC   = 64;
    localparam int NB_DATA = 64;
    localparam int NB_REG  = 5;
    localparam int NB_CNT  = 4;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               zero;
        logic [NB_PC-1:0]   branch_address;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] store_data;
        logic [NB_REG-1:0]  selected_reg;
    } pl_t;

    logic clk, rst, flush, ex_valid, ex_ready, mem_valid, mem_ready;
    pl_t  in_pl;
    logic               m_reg_write, m_mem_to_reg, m_mem_read, m_mem_write, m_branch, m_zero;
    logic [NB_PC-1:0]   m_branch_address;
    logic [NB_DATA-1:0] m_alu_result, m_store_data;
    logic [NB_REG-1:0]  m_selected_reg;
    logic [NB_CNT-1:0]  bubble_count;

    int  checks;
    int  failures;
    pl_t mq[$];
    int  mdl_bub;

    ex_mem_stage_reg #(.NB_PC(NB_PC), .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
        .i_clock(clk), .i_reset(rst), .i_flush(flush),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
        .i_ex_reg_write(in_pl.reg_write), .i_ex_mem_to_reg(in_pl.mem_to_reg),
        .i_ex_mem_read(in_pl.mem_read), .i_ex_mem_write(in_pl.mem_write),
        .i_ex_branch(in_pl.branch), .i_ex_zero(in_pl.zero),
        .i_ex_branch_address(in_pl.branch_address), .i_ex_alu_result(in_pl.alu_result),
        .i_ex_store_data(in_pl.store_data), .i_ex_selected_reg(in_pl.selected_reg),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready),
        .o_mem_reg_write(m_reg_write), .o_mem_mem_to_reg(m_mem_to_reg),
        .o_mem_mem_read(m_mem_read), .o_mem_mem_write(m_mem_write),
        .o_mem_branch(m_branch), .o_mem_zero(m_zero),
        .o_mem_branch_address(m_branch_address), .o_mem_alu_result(m_alu_result),
        .o_mem_store_data(m_store_data), .o_mem_selected_reg(m_selected_reg),
        .o_bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pl_t dut_out();
        return {m_reg_write, m_mem_to_reg, m_mem_read, m_mem_write, m_branch, m_zero,
                m_branch_address, m_alu_result, m_store_data, m_selected_reg};
    endfunction

    function automatic pl_t rand_pl();
        pl_t p;
        p.reg_write      = 1'($urandom);
        p.mem_to_reg     = 1'($urandom);
        p.mem_read       = 1'($urandom);
        p.mem_write      = 1'($urandom);
        p.branch         = 1'($urandom);
        p.zero           = 1'($urandom);
        p.branch_address = {$urandom, $urandom};
        p.alu_result     = {$urandom, $urandom};
        p.store_data     = {$urandom, $urandom};
        p.selected_reg   = 5'($urandom);
        return p;
    endfunction

    // Capacity-based acceptance rule: one slot (refillable while draining) or two registered slots.
    function automatic logic mdl_ready();
`ifdef EX_MEM_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || mem_ready;
`endif
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic in_t, out_t;
        pl_t  cur;
        cur   = in_pl;
        in_t  = ex_valid && mdl_ready();
        out_t = (mq.size() > 0) && mem_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mdl_bub = 0;
        end else begin
            if (flush) begin
                mq.delete();
            end else begin
                if (out_t) mq.delete(0);
                if (in_t) mq.push_back(cur);
            end
            if (mq.size() == 0 && mdl_bub < 15) mdl_bub++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0; in_pl = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", mem_valid); end
        checks++;
        if (dut_out() !== pl_t'(0)) begin failures++; $display("FAIL reset_payload got=%h want=0", dut_out()); end
        checks++;
        if (bubble_count !== 4'd5) begin failures++; $display("FAIL reset_bubbles got=%0d want=5", bubble_count); end
    endtask

    task automatic test_stream();
        logic [NB_DATA-1:0] exp_alu;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pl = rand_pl();
            in_pl.alu_result = 64'(16 * (i + 1));
            ex_valid = 1'b1;
            #1;
            checks++;
            if (ex_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=%b want=1", i, ex_ready); end
            tick();
            exp_alu = 64'(16 * (i + 1));
            checks++;
            if (mem_valid !== 1'b1 || m_alu_result !== exp_alu) begin
                failures++;
                $display("FAIL stream_data i=%0d got=%b/%h want=1/%h", i, mem_valid, m_alu_result, exp_alu);
            end
            checks++;
            if (bubble_count !== 4'(mdl_bub)) begin
                failures++; $display("FAIL stream_bubbles i=%0d got=%0d want=%0d", i, bubble_count, mdl_bub);
            end
        end
        ex_valid = 1'b0;
        tick();
        checks++;
        if (mem_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b want=0", mem_valid); end
    endtask

    task automatic test_stall();
        logic exp_rdy;
        mem_ready = 1'b0; ex_valid = 1'b1;
        in_pl = rand_pl();
        in_pl.alu_result = 64'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_pl = rand_pl();
            in_pl.alu_result = 64'h1111 + 64'(i);
            #1;
`ifdef EX_MEM_SKID_EN
            exp_rdy = (i == 0);
`else
            exp_rdy = 1'b0;
`endif
            checks++;
            if (ex_ready !== exp_rdy) begin failures++; $display("FAIL stall_ready i=%0d got=%b want=%b", i, ex_ready, exp_rdy); end
            tick();
            checks++;
            if (mem_valid !== 1'b1 || m_alu_result !== 64'hDEAD_BEEF) begin
                failures++; $display("FAIL stall_hold i=%0d got=%b/%h want=1/deadbeef", i, mem_valid, m_alu_result);
            end
        end
        ex_valid = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_valid !== (mq.size() > 0) || (mq.size() > 0 && dut_out() !== mq[0])) begin
                failures++; $display("FAIL stall_drain i=%0d got=%b/%h", i, mem_valid, m_alu_result);
            end
        end
    endtask

    task automatic test_reset_stall();
        mem_ready = 1'b0; ex_valid = 1'b1; in_pl = rand_pl();
        tick();
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        checks++;
        if (mem_valid !== 1'b0 || dut_out() !== pl_t'(0) || bubble_count !== 4'd0) begin
            failures++; $display("FAIL reset_stall got=%b/%h/%0d want=0/0/0", mem_valid, dut_out(), bubble_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        mem_ready = 1'b0; ex_valid = 1'b1;
        in_pl = rand_pl();
        in_pl.mem_write = 1'b1; in_pl.reg_write = 1'b1; in_pl.alu_result = 64'hAAAA;
        tick();
        checks++;
        if (mem_valid !== 1'b1 || m_mem_write !== 1'b1) begin
            failures++; $display("FAIL flush_setup got=%b/%b want=1/1", mem_valid, m_mem_write);
        end
        flush = 1'b1; in_pl.alu_result = 64'h5555;
        tick();
        checks++;
        if (mem_valid !== 1'b0 || m_mem_write !== 1'b0 || m_reg_write !== 1'b0) begin
            failures++; $display("FAIL flush_squash got=%b/%b/%b want=0/0/0", mem_valid, m_mem_write, m_reg_write);
        end
        flush = 1'b0; ex_valid = 1'b0;
        tick();
        checks++;
        if (mem_valid !== 1'b0 || m_alu_result === 64'h5555) begin
            failures++; $display("FAIL flush_discard got=%b/%h want=0/not 5555", mem_valid, m_alu_result);
        end
    endtask

    task automatic test_saturate();
        ex_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bubble_count !== 4'd15 || mem_valid !== 1'b0) begin
            failures++; $display("FAIL saturate got=%0d/%b want=15/0", bubble_count, mem_valid);
        end
    endtask

    task automatic test_wide();
        mem_ready = 1'b1; ex_valid = 1'b1;
        in_pl = rand_pl();
        in_pl.store_data = 64'h0123_4567_89AB_CDEF;
        in_pl.branch_address = 64'hFEDC_BA98_7654_3210;
        tick();
        ex_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1 || m_store_data !== 64'h0123_4567_89AB_CDEF || m_branch_address !== 64'hFEDC_BA98_7654_3210) begin
            failures++; $display("FAIL wide_data got=%b/%h/%h", mem_valid, m_store_data, m_branch_address);
        end
        tick();
    endtask

    task automatic test_random();
        pl_t got;
        for (int c = 0; c < 400; c++) begin
            ex_valid  = ($urandom_range(0, 3) != 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_pl     = rand_pl();
            #1;
            checks++;
            if (ex_ready !== mdl_ready()) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, ex_ready, mdl_ready());
            end
            tick();
            got = dut_out();
            checks++;
            if (mem_valid !== (mq.size() > 0)) begin
                failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, mem_valid, mq.size() > 0);
            end else if (mq.size() > 0) begin
                if (got !== mq[0]) begin
                    failures++; $display("FAIL rand_payload cyc=%0d got=%h want=%h", c, got, mq[0]);
                end
            end else if ({m_reg_write, m_mem_read, m_mem_write, m_branch} !== 4'b0000) begin
                failures++;
                $display("FAIL rand_gating cyc=%0d got=%b want=0000", c, {m_reg_write, m_mem_read, m_mem_write, m_branch});
            end
            checks++;
            if (bubble_count !== 4'(mdl_bub)) begin
                failures++; $display("FAIL rand_bubbles cyc=%0d got=%0d want=%0d", c, bubble_count, mdl_bub);
            end
        end
        flush = 1'b0; ex_valid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; mdl_bub = 0;
        test_reset();
        test_stream();
        test_stall();
        test_reset_stall();
        test_flush();
        test_saturate();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
